// File: rtl/core_id.sv
// -----------------------------------------------------------------------------
// core_id -- instruction-decode stage of the i2d core.
//
// Registers the {pc, instr, err} triple coming from instruction fetch, exposes
// the decoded fields to the register file and execute stage, and drives a
// registered halt request back to fetch. Fetch swaps its output for a NOP
// while halted, so any live instruction that cannot enter ID is parked in a
// one-entry skid buffer. A fetch bus error is trapped: once an erroneous word
// reaches ID, the stage halts fetch and issues bubbles until a flush.
//
// Configuration macro:
//   I2D_ID_HAZARD_EN  defined     : load-use interlock (LW followed by a
//                                   consumer of its rd costs one bubble).
//                     not defined : no interlock; the compiler fills load
//                                   delay slots. The skid is then entered
//                                   only through ex_stall.
//
// Ports:
//   clk        in   core clock, rising-edge
//   rst        in   synchronous reset, active low
//   if_pc      in   pc of the fetched word
//   if_instr   in   fetched word; opcode OPCODE_NOP marks a bubble
//   if_err     in   fetch bus error for the current word
//   flush      in   pipeline redirect (same cycle as fetch set_pc)
//   ex_stall   in   execute cannot accept a new instruction
//   if_halt    out  registered halt request to fetch
//   id_valid   out  ID register holds a real instruction
//   id_pc      out  pc of the ID instruction
//   id_instr   out  the ID instruction
//   id_opcode  out  instr[31:26]
//   id_rd      out  instr[25:21]
//   id_rs1     out  instr[20:16], register-file read address
//   id_rs2     out  instr[15:11], register-file read address
//   id_imm     out  instr[15:0] sign-extended
//   id_err     out  the ID instruction carries a fetch error
// -----------------------------------------------------------------------------

package i2d_core_pkg;

  localparam int ADDR_W   = 32;
  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam logic [OPCODE_W-1:0] OPCODE_NOP = 6'h00;
  localparam logic [OPCODE_W-1:0] OPCODE_LW  = 6'h23;

  // Canonical bubble word loaded into ID whenever it must carry no instruction.
  localparam instr_t INSTR_NOP = {OPCODE_NOP, 26'b0};

endpackage

module core_id
  import i2d_core_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   if_pc,
  input  logic [INSTR_W-1:0]  if_instr,
  input  logic                if_err,
  input  logic                flush,
  input  logic                ex_stall,
  output logic                if_halt,
  output logic                id_valid,
  output logic [ADDR_W-1:0]   id_pc,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [OPCODE_W-1:0] id_opcode,
  output logic [REG_W-1:0]    id_rd,
  output logic [REG_W-1:0]    id_rs1,
  output logic [REG_W-1:0]    id_rs2,
  output logic [ADDR_W-1:0]   id_imm,
  output logic                id_err
);

  // RUN : skid empty, fetch running
  // HOLD: skid holds a live word, fetch halted
  // ERR : fetch error trapped in ID, fetch halted until flush
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
    logic   err;
  } fetch_word_t;

  state_e      state_q,    state_d;
  logic        halt_q,     halt_d;
  logic        id_valid_q, id_valid_d;
  fetch_word_t id_q,       id_d;
  fetch_word_t skid_q,     skid_d;

  fetch_word_t in_word;
  logic        in_live;
  logic        hazard;

  assign in_word = '{pc: if_pc, instr: if_instr, err: if_err};

  // An erroneous word is live even if its (garbage) opcode reads as NOP,
  // so the error is never silently dropped.
  assign in_live = if_err || (if_instr[31:26] != OPCODE_NOP);

`ifdef I2D_ID_HAZARD_EN
  instr_t           src_instr;
  logic [REG_W-1:0] ld_rd;
  logic             src_live;

  // In HOLD the candidate for ID is the parked word; in RUN it is the word
  // arriving from fetch. The skid only ever holds live words.
  always_comb begin
    src_instr = (state_q == ST_HOLD) ? skid_q.instr : if_instr;
    src_live  = (state_q == ST_HOLD) ? 1'b1 : in_live;
    ld_rd     = id_q.instr[25:21];
    hazard    = id_valid_q
             && (id_q.instr[31:26] == OPCODE_LW)
             && (ld_rd != '0)
             && src_live
             && ((src_instr[20:16] == ld_rd) || (src_instr[15:11] == ld_rd));
  end
`else
  assign hazard = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the
    // branches below can leave a variable unassigned and infer a latch.
    state_d    = state_q;
    id_valid_d = id_valid_q;
    id_d       = id_q;
    skid_d     = skid_q;

    if (flush) begin
      // Redirect wins over everything. Returning to RUN is what empties the
      // skid; its stale contents are never read outside HOLD.
      id_valid_d = 1'b0;
      id_d.err   = 1'b0;
      state_d    = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ex_stall) begin
            if (in_live) begin
              skid_d  = in_word;
              state_d = ST_HOLD;
            end
          end else if (hazard) begin
            id_valid_d   = 1'b0;
            id_d.instr   = INSTR_NOP;
            id_d.err     = 1'b0;
            skid_d       = in_word;
            state_d      = ST_HOLD;
          end else begin
            id_valid_d = in_live;
            id_d       = in_word;
            if (if_err) state_d = ST_ERR;
          end
        end

        ST_HOLD: begin
          if (ex_stall) begin
            // hold everything
          end else if (hazard) begin
            id_valid_d = 1'b0;
            id_d.instr = INSTR_NOP;
            id_d.err   = 1'b0;
          end else begin
            // Drain the skid; an erroneous parked word traps just like one
            // arriving directly from fetch.
            id_valid_d = 1'b1;
            id_d       = skid_q;
            state_d    = skid_q.err ? ST_ERR : ST_RUN;
          end
        end

        ST_ERR: begin
          if (!ex_stall) begin
            id_valid_d = 1'b0;
            id_d.instr = INSTR_NOP;
            id_d.err   = 1'b0;
          end
        end

        default: begin
          state_d    = ST_RUN;
          id_valid_d = 1'b0;
        end
      endcase
    end

    // Halt is a pure function of the next state and is then registered, so
    // fetch never sees a combinational path from any ID input.
    halt_d = (state_d != ST_RUN);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      halt_q     <= 1'b0;
      id_valid_q <= 1'b0;
      id_q       <= '{pc: '0, instr: INSTR_NOP, err: 1'b0};
      skid_q     <= '{pc: '0, instr: INSTR_NOP, err: 1'b0};
    end else begin
      state_q    <= state_d;
      halt_q     <= halt_d;
      id_valid_q <= id_valid_d;
      id_q       <= id_d;
      skid_q     <= skid_d;
    end
  end

  assign if_halt   = halt_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_q.pc;
  assign id_instr  = id_q.instr;
  assign id_err    = id_q.err;
  assign id_opcode = id_q.instr[31:26];
  assign id_rd     = id_q.instr[25:21];
  assign id_rs1    = id_q.instr[20:16];
  assign id_rs2    = id_q.instr[15:11];
  assign id_imm    = {{16{id_q.instr[15]}}, id_q.instr[15:0]};

endmodule
